// File: rtl/tex_dcache_responder.sv
// Dcache-side responder for the texture unit: per-lane reads/writes into a local word memory,
// one coalesced read response per accepting cycle after a fixed latency, credit-limited queue.
module tex_dcache_responder #(
  parameter int NUM_REQS   = 4,
  parameter int TAG_WIDTH  = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4,
  parameter int QUEUE_SIZE = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS-1:0]                 req_rw,
  input  logic [NUM_REQS-1:0][29:0]           req_addr,
  input  logic [NUM_REQS-1:0][3:0]            req_byteen,
  input  logic [NUM_REQS-1:0][31:0]           req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]                 req_ready,
  input  logic [NUM_REQS-1:0]                 req_stall,
  output logic                                rsp_valid,
  output logic [NUM_REQS-1:0]                 rsp_tmask,
  output logic [NUM_REQS-1:0][31:0]           rsp_data,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  input  logic                                rsp_ready
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int PTR_W  = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CNT_W  = $clog2(QUEUE_SIZE + 1);
  localparam logic [CNT_W-1:0] QS_CNT   = CNT_W'(QUEUE_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_SIZE - 1);

  logic [31:0]                  mem [MEM_DEPTH];
  logic [NUM_REQS-1:0]          fire, fire_rd, fire_wr;
  logic                         rd_any, pop, push;
  logic [NUM_REQS-1:0][31:0]    rd_data;
  logic [TAG_WIDTH-1:0]         rd_tag;
  logic [CNT_W-1:0]             outstanding;
  logic                         unused_addr;

  logic [LATENCY-1:0]           pipe_valid;
  logic [NUM_REQS-1:0]          pipe_tmask [LATENCY];
  logic [NUM_REQS-1:0][31:0]    pipe_data  [LATENCY];
  logic [TAG_WIDTH-1:0]         pipe_tag   [LATENCY];

  logic [NUM_REQS-1:0]          q_tmask [QUEUE_SIZE];
  logic [NUM_REQS-1:0][31:0]    q_data  [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]         q_tag   [QUEUE_SIZE];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             q_count;

  // Only the low ADDR_W address bits select a word; the rest wrap away.
  assign unused_addr = ^req_addr;

  assign req_ready = {NUM_REQS{~reset & (outstanding < QS_CNT)}} & ~req_stall;
  assign fire      = req_valid & req_ready;
  assign fire_rd   = fire & ~req_rw;
  assign fire_wr   = fire & req_rw;
  assign rd_any    = |fire_rd;
  assign push      = pipe_valid[LATENCY-1];
  assign pop       = rsp_valid & rsp_ready;

  // Read-first lookup and lead tag (lowest fired read lane) for the new entry.
  always_comb begin
    rd_data = '0;
    rd_tag  = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      rd_data[i] = fire_rd[i] ? mem[req_addr[i][ADDR_W-1:0]] : 32'h0;
      rd_tag     = fire_rd[i] ? req_tag[i] : rd_tag;
    end
  end

  // Byte-masked writes; later lanes are written last so the higher lane wins per byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (fire_wr[i] && req_byteen[i][b]) begin
          mem[req_addr[i][ADDR_W-1:0]][b*8 +: 8] <= req_data[i][b*8 +: 8];
        end
      end
    end
  end

  // Credit counter covering the delay pipe and the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rd_any && !pop) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!rd_any && pop) begin
      outstanding <= outstanding - CNT_W'(1);
    end else begin
      outstanding <= outstanding;
    end
  end

  // Non-stallable delay pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_tmask[s] <= '0;
        pipe_data[s]  <= '0;
        pipe_tag[s]   <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_any;
      pipe_tmask[0] <= fire_rd;
      pipe_data[0]  <= rd_data;
      pipe_tag[0]   <= rd_tag;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_tmask[s] <= pipe_tmask[s-1];
        pipe_data[s]  <= pipe_data[s-1];
        pipe_tag[s]   <= pipe_tag[s-1];
      end
    end
  end

  // Queue storage; contents behind rd_ptr are masked off while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_tmask[wr_ptr] <= pipe_tmask[LATENCY-1];
      q_data[wr_ptr]  <= pipe_data[LATENCY-1];
      q_tag[wr_ptr]   <= pipe_tag[LATENCY-1];
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      wr_ptr  <= push ? ((wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1)) : wr_ptr;
      rd_ptr  <= pop  ? ((rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1)) : rd_ptr;
      q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rsp_valid = (q_count != '0);
  assign rsp_tmask = rsp_valid ? q_tmask[rd_ptr] : '0;
  assign rsp_data  = rsp_valid ? q_data[rd_ptr]  : '0;
  assign rsp_tag   = rsp_valid ? q_tag[rd_ptr]   : '0;

  // All read lanes fired together must share one tag.
  read_tags_equal: assert property (@(posedge clk) disable iff (reset)
    (fire_rd & ~(fire_rd & {NUM_REQS{1'b0}})) == '0 ||
    (({NUM_REQS{1'b1}} & fire_rd) != '0 && tags_match(fire_rd, req_tag, rd_tag)))
    else $error("tex_dcache_responder: fired read lanes carry different tags");

  function automatic logic tags_match(input logic [NUM_REQS-1:0] lanes,
                                      input logic [NUM_REQS-1:0][TAG_WIDTH-1:0] tags,
                                      input logic [TAG_WIDTH-1:0] lead);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      ok = ok & (~lanes[i] | (tags[i] == lead));
    end
    return ok;
  endfunction
endmodule

// File: tb/tb_tex_dcache_responder.sv
// Directed self-checking bench for tex_dcache_responder with default parameters.
module tb_tex_dcache_responder;
  logic              clk;
  logic              reset;
  logic [3:0]        req_valid, req_rw, req_stall, req_ready;
  logic [3:0][29:0]  req_addr;
  logic [3:0][3:0]   req_byteen;
  logic [3:0][31:0]  req_data;
  logic [3:0][15:0]  req_tag;
  logic              rsp_valid, rsp_ready;
  logic [3:0]        rsp_tmask;
  logic [3:0][31:0]  rsp_data;
  logic [15:0]       rsp_tag;

  typedef struct packed {
    logic [3:0]   tmask;
    logic [127:0] data;
    logic [15:0]  tag;
  } rsp_t;
  rsp_t rx[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] bp_addr [8] = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h200, 30'h300, 30'h100, 30'h101};
  logic [31:0] bp_exp  [8] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h1122AA44, 32'h11112222, 32'hA0, 32'hA1};

  tex_dcache_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_byteen(req_byteen),
    .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready), .req_stall(req_stall),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every accepted response; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) rx.push_back({rsp_tmask, rsp_data, rsp_tag});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_valid = 4'b0000;
    req_rw    = 4'b0000;
  endtask

  task automatic set_lane(input int l, input logic rw, input logic [29:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic [15:0] t);
    req_valid[l] = 1'b1;
    req_rw[l] = rw;
    req_addr[l] = a;
    req_byteen[l] = be;
    req_data[l] = d;
    req_tag[l] = t;
  endtask

  task automatic wr0(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    set_lane(0, 1'b1, a, be, d, 16'h0);
    cyc();
    idle();
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 20 && rx.size() < n; k++) cyc();
    check_val("rx_count", 128'(rx.size()), 128'(n));
  endtask

  task automatic chk_rsp(input string nm, input int idx, input logic [3:0] tm,
                         input logic [127:0] d, input logic [15:0] tg);
    check_val({nm, "_tmask"}, 128'(rx[idx].tmask), 128'(tm));
    check_val({nm, "_data"}, rx[idx].data, d);
    check_val({nm, "_tag"}, 128'(rx[idx].tag), 128'(tg));
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; req_stall = 4'b0000;
    req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
    cyc();
    check_val("ready_in_reset", 128'(req_ready), 128'(4'b0000));
    cyc();
    check_val("rst_valid", 128'(rsp_valid), 128'(1'b0));
    check_val("rst_tmask", 128'(rsp_tmask), 128'(4'b0000));
    check_val("rst_data", 128'(rsp_data), 128'(0));
    check_val("rst_tag", 128'(rsp_tag), 128'(16'h0));
    reset = 1'b0;
    req_stall = 4'b0101;
    #1;
    check_val("ready_vs_stall", 128'(req_ready), 128'(4'b1010));
    req_stall = 4'b0000;

    // Preload and four-lane read with latency check
    for (int k = 0; k < 4; k++) wr0(30'(32'h100 + k), 32'(32'hA0 + k), 4'b1111);
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 30'(32'h100 + l), 4'b0000, 32'h0, 16'd5);
    cyc();
    idle();
    cyc(); cyc(); cyc();
    check_val("lat_early", 128'(rsp_valid), 128'(1'b0));
    cyc();
    check_val("lat_valid", 128'(rsp_valid), 128'(1'b1));
    check_val("lat_tmask", 128'(rsp_tmask), 128'(4'b1111));
    check_val("lat_data", 128'(rsp_data), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check_val("lat_tag", 128'(rsp_tag), 128'(16'd5));
    cyc();
    check_val("lat_pulse", 128'(rsp_valid), 128'(1'b0));

    // Partial acceptance
    rx.delete();
    for (int l = 0; l < 4; l++) set_lane(l, 1'b0, 30'(32'h100 + l), 4'b0000, 32'h0, 16'd3);
    req_stall = 4'b1100;
    #1;
    check_val("stall_ready", 128'(req_ready), 128'(4'b0011));
    cyc();
    req_stall = 4'b0000;
    req_valid = 4'b1100;
    cyc();
    idle();
    wait_rx(2);
    chk_rsp("part0", 0, 4'b0011, {64'h0, 32'hA1, 32'hA0}, 16'd3);
    chk_rsp("part1", 1, 4'b1100, {32'hA3, 32'hA2, 64'h0}, 16'd3);

    // Byte enables, read-first, higher lane wins
    rx.delete();
    wr0(30'h200, 32'h11223344, 4'b1111);
    set_lane(0, 1'b1, 30'h200, 4'b0010, 32'h0000AA00, 16'd0);
    set_lane(1, 1'b0, 30'h200, 4'b0000, 32'h0, 16'd7);
    cyc();
    idle();
    set_lane(0, 1'b0, 30'h200, 4'b0000, 32'h0, 16'd8);
    cyc();
    idle();
    set_lane(0, 1'b1, 30'h300, 4'b1111, 32'h11111111, 16'd0);
    set_lane(2, 1'b1, 30'h300, 4'b0011, 32'h22222222, 16'd0);
    cyc();
    idle();
    set_lane(3, 1'b0, 30'h300, 4'b0000, 32'h0, 16'd9);
    cyc();
    idle();
    wait_rx(3);
    chk_rsp("rdfirst", 0, 4'b0010, {64'h0, 32'h11223344, 32'h0}, 16'd7);
    chk_rsp("byteen", 1, 4'b0001, 128'(32'h1122AA44), 16'd8);
    chk_rsp("lanewin", 2, 4'b1000, {32'h11112222, 96'h0}, 16'd9);

    // Backpressure with a full queue
    rsp_ready = 1'b0;
    rx.delete();
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 1'b0, bp_addr[k], 4'b0000, 32'h0, 16'(20 + k));
      #1;
      check_val("bp_ready", 128'(req_ready[0]), 128'(1'b1));
      cyc();
    end
    idle();
    #1;
    check_val("bp_full", 128'(req_ready), 128'(4'b0000));
    repeat (6) cyc();
    check_val("bp_head_valid", 128'(rsp_valid), 128'(1'b1));
    check_val("bp_head_tag", 128'(rsp_tag), 128'(16'd20));
    repeat (2) cyc();
    check_val("bp_head_stable", 128'(rsp_tag), 128'(16'd20));
    check_val("bp_head_data", 128'(rsp_data), 128'(32'hA0));
    check_val("bp_still_full", 128'(req_ready), 128'(4'b0000));
    rsp_ready = 1'b1;
    #1;
    check_val("bp_full_until_fire", 128'(req_ready), 128'(4'b0000));
    cyc();
    check_val("bp_ready_return", 128'(req_ready), 128'(4'b1111));
    set_lane(0, 1'b0, 30'h100, 4'b0000, 32'h0, 16'd30);
    cyc();
    idle();
    #1;
    check_val("bp_ready_hold", 128'(req_ready), 128'(4'b1111));
    wait_rx(9);
    for (int k = 0; k < 8; k++) begin
      check_val("bp_order_tag", 128'(rx[k].tag), 128'(16'(20 + k)));
      check_val("bp_order_data", rx[k].data, 128'(bp_exp[k]));
    end
    chk_rsp("bp_extra", 8, 4'b0001, 128'(32'hA0), 16'd30);

    // Reset with reads in flight
    rx.delete();
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b0, 30'h101, 4'b0000, 32'h0, 16'(40 + k));
      cyc();
    end
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("midrst_valid", 128'(rsp_valid), 128'(1'b0));
    repeat (10) cyc();
    check_val("midrst_no_stale", 128'(rx.size()), 128'(0));
    set_lane(0, 1'b0, 30'h100, 4'b0000, 32'h0, 16'd50);
    cyc();
    idle();
    wait_rx(1);
    chk_rsp("mem_persist", 0, 4'b0001, 128'(32'hA0), 16'd50);

    // Address wrap modulo depth
    rx.delete();
    wr0(30'h000, 32'hDEADBEEF, 4'b1111);
    set_lane(0, 1'b0, 30'h400, 4'b0000, 32'h0, 16'd60);
    cyc();
    idle();
    wait_rx(1);
    chk_rsp("wrap", 0, 4'b0001, 128'(32'hDEADBEEF), 16'd60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
